// File: rtl/uart_cmd_parser_pkg.sv
// Shared constants, state type and hex helpers for the UART command-frame parser.
package uart_cmd_pkg;

   localparam logic [7:0] SOF       = 8'h21;
   localparam logic [7:0] BCAST     = 8'h2A;
   localparam logic [7:0] EOF_CR    = 8'h0D;
   localparam logic [7:0] CHAN_BASE = 8'h41;

   typedef enum logic [1:0] {
      StIdle,
      StChan,
      StData,
      StTerm
   } state_e;

   function automatic logic is_hex(input logic [7:0] b);
      return ((b >= 8'h30) && (b <= 8'h39)) ||
             ((b >= 8'h41) && (b <= 8'h46)) ||
             ((b >= 8'h61) && (b <= 8'h66));
   endfunction

   // Only meaningful when is_hex(b) is true.
   function automatic logic [3:0] hex2nib(input logic [7:0] b);
      logic [7:0] v;
      if (b <= 8'h39) begin
         v = b - 8'h30;
      end else if (b <= 8'h46) begin
         v = b - 8'h37;
      end else begin
         v = b - 8'h57;
      end
      return v[3:0];
   endfunction

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Byte stream in, per-channel command registers and error status out.
interface uart_cmd_parser_if #(
   parameter int unsigned NCH  = 2,
   parameter int unsigned NDIG = 4
);
   localparam int unsigned W = 4 * NDIG;

   logic [7:0]       rx_byte;
   logic             rx_dv;
   logic [NCH-1:0]   cmd_clear;
   logic [NCH*W-1:0] cmd_val;
   logic [NCH-1:0]   cmd_set;
   logic             frame_err;
   logic [7:0]       err_cnt;

   modport master (
      output rx_byte, rx_dv, cmd_clear,
      input  cmd_val, cmd_set, frame_err, err_cnt
   );

   modport slave (
      input  rx_byte, rx_dv, cmd_clear,
      output cmd_val, cmd_set, frame_err, err_cnt
   );

endinterface

// File: rtl/uart_cmd_parser.sv
// Decodes "!<chan><NDIG hex digits>\r" frames into per-channel command registers with
// sticky new-command flags, plus frame error detection, inter-byte timeout and error count.
module uart_cmd_parser
   import uart_cmd_pkg::*;
#(
   parameter int unsigned NCH          = 2,
   parameter int unsigned NDIG         = 4,
   parameter int unsigned TIMEOUT_CLKS = 43400
) (
   input logic           clk,
   input logic           rst_n,
   uart_cmd_parser_if.slave bus
);

   localparam int unsigned W  = 4 * NDIG;
   localparam int unsigned CW = $clog2(NDIG + 1);
   localparam int unsigned TW = $clog2(TIMEOUT_CLKS + 1);

   state_e           r_state, w_state_d;
   logic [NCH-1:0]   r_mask;
   logic [W-1:0]     r_acc;
   logic [CW-1:0]    r_dcnt;
   logic [TW-1:0]    r_tmo;
   logic [NCH*W-1:0] r_val;
   logic [NCH-1:0]   r_set, w_set_d;
   logic             r_ferr;
   logic [7:0]       r_ecnt;

   logic [7:0]       w_chan_off;
   logic [NCH-1:0]   w_chan_mask;
   logic             w_chan_ok;
   logic             w_tmo_hit;
   logic             w_err, w_commit, w_load, w_shift;

   assign w_chan_off = bus.rx_byte - CHAN_BASE;
   assign w_chan_ok  = (bus.rx_byte == BCAST) ||
                       ((bus.rx_byte >= CHAN_BASE) && (w_chan_off < 8'(NCH)));
   assign w_tmo_hit  = (r_state != StIdle) && !bus.rx_dv && (r_tmo == TW'(TIMEOUT_CLKS - 1));

   always_comb begin
      w_chan_mask = '0;
      for (int i = 0; i < int'(NCH); i++) begin
         w_chan_mask[i] = (bus.rx_byte == BCAST) || (w_chan_off == 8'(i));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_d;
      end
   end

   // A '!' anywhere inside a frame is an error but also the start of a fresh frame.
   always_comb begin
      w_state_d = r_state;
      w_err     = 1'b0;
      w_commit  = 1'b0;
      w_load    = 1'b0;
      w_shift   = 1'b0;
      if (w_tmo_hit) begin
         w_err     = 1'b1;
         w_state_d = StIdle;
      end else if (bus.rx_dv) begin
         case (r_state)
            StIdle: begin
               if (bus.rx_byte == SOF) w_state_d = StChan;
            end
            StChan: begin
               if (bus.rx_byte == SOF) begin
                  w_err = 1'b1;
               end else if (w_chan_ok) begin
                  w_load    = 1'b1;
                  w_state_d = StData;
               end else begin
                  w_err     = 1'b1;
                  w_state_d = StIdle;
               end
            end
            StData: begin
               if (bus.rx_byte == SOF) begin
                  w_err     = 1'b1;
                  w_state_d = StChan;
               end else if (is_hex(bus.rx_byte)) begin
                  w_shift = 1'b1;
                  if (r_dcnt == CW'(NDIG - 1)) w_state_d = StTerm;
               end else begin
                  w_err     = 1'b1;
                  w_state_d = StIdle;
               end
            end
            StTerm: begin
               if (bus.rx_byte == SOF) begin
                  w_err     = 1'b1;
                  w_state_d = StChan;
               end else if (bus.rx_byte == EOF_CR) begin
                  w_commit  = 1'b1;
                  w_state_d = StIdle;
               end else begin
                  w_err     = 1'b1;
                  w_state_d = StIdle;
               end
            end
            default: w_state_d = StIdle;
         endcase
      end
   end

   // Commit is ORed in after the clear so a same-cycle acknowledge cannot drop a new command.
   always_comb begin
      w_set_d = r_set & ~bus.cmd_clear;
      if (w_commit) w_set_d = w_set_d | r_mask;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mask <= '0;
         r_acc  <= '0;
         r_dcnt <= '0;
         r_tmo  <= '0;
         r_val  <= '0;
         r_set  <= '0;
         r_ferr <= 1'b0;
         r_ecnt <= '0;
      end else begin
         if (bus.rx_dv || (w_state_d == StIdle)) begin
            r_tmo <= '0;
         end else begin
            r_tmo <= r_tmo + 1'b1;
         end
         if (w_load) begin
            r_mask <= w_chan_mask;
            r_acc  <= '0;
            r_dcnt <= '0;
         end else if (w_shift) begin
            r_acc  <= (r_acc << 4) | W'(hex2nib(bus.rx_byte));
            r_dcnt <= r_dcnt + 1'b1;
         end
         if (w_commit) begin
            for (int i = 0; i < int'(NCH); i++) begin
               if (r_mask[i]) r_val[i*W +: W] <= r_acc;
            end
         end
         r_set  <= w_set_d;
         r_ferr <= w_err;
         if (w_err && (r_ecnt != 8'hFF)) r_ecnt <= r_ecnt + 1'b1;
      end
   end

   assign bus.cmd_val   = r_val;
   assign bus.cmd_set   = r_set;
   assign bus.frame_err = r_ferr;
   assign bus.err_cnt   = r_ecnt;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed test of uart_cmd_parser: decode, broadcast, clear, errors, resync, timeout, reset.
module tb_uart_cmd_parser;

   localparam int unsigned NCH  = 2;
   localparam int unsigned NDIG = 4;
   localparam int unsigned TMO  = 100;
   localparam logic [7:0]  CR   = 8'h0D;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_err;
   int   waited;

   uart_cmd_parser_if #(.NCH(NCH), .NDIG(NDIG)) bus ();

   uart_cmd_parser #(
      .NCH         (NCH),
      .NDIG        (NDIG),
      .TIMEOUT_CLKS(TMO)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called on a falling edge; returns on the falling edge after the byte was sampled.
   task automatic send_byte(input logic [7:0] b);
      bus.rx_byte = b;
      bus.rx_dv   = 1'b1;
      @(negedge clk);
      bus.rx_dv   = 1'b0;
      bus.rx_byte = 8'h00;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i]);
   endtask

   initial begin
      n_chk         = 0;
      n_err         = 0;
      waited        = 0;
      rst_n         = 1'b0;
      bus.rx_byte   = 8'h00;
      bus.rx_dv     = 1'b0;
      bus.cmd_clear = '0;
      repeat (2) @(negedge clk);
      check("rst_val", bus.cmd_val, 32'h0);
      check("rst_set", 32'(bus.cmd_set), 32'h0);
      check("rst_ferr", 32'(bus.frame_err), 32'h0);
      check("rst_ecnt", 32'(bus.err_cnt), 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // Single channel, mixed-case hex
      send_str("!A12Ef");
      send_byte(CR);
      check("ch0_val", bus.cmd_val, 32'h0000_12EF);
      check("ch0_set", 32'(bus.cmd_set), 32'h1);
      check("ch0_ferr", 32'(bus.frame_err), 32'h0);
      check("ch0_ecnt", 32'(bus.err_cnt), 32'h0);

      // Broadcast then clear channel 1
      send_str("!*00FF");
      send_byte(CR);
      check("bc_val", bus.cmd_val, 32'h00FF_00FF);
      check("bc_set", 32'(bus.cmd_set), 32'h3);
      bus.cmd_clear = 2'b10;
      @(negedge clk);
      bus.cmd_clear = 2'b00;
      check("clr_set", 32'(bus.cmd_set), 32'h1);
      check("clr_val", bus.cmd_val, 32'h00FF_00FF);

      // Bad channel
      send_str("!C");
      check("badch_ferr", 32'(bus.frame_err), 32'h1);
      check("badch_ecnt", 32'(bus.err_cnt), 32'h1);
      send_str("1234");
      send_byte(CR);
      check("badch_ferr_off", 32'(bus.frame_err), 32'h0);
      check("badch_ecnt2", 32'(bus.err_cnt), 32'h1);
      check("badch_val", bus.cmd_val, 32'h00FF_00FF);
      check("badch_set", 32'(bus.cmd_set), 32'h1);

      // Resync on '!' mid-frame
      bus.cmd_clear = 2'b11;
      @(negedge clk);
      bus.cmd_clear = 2'b00;
      send_str("!A12!");
      check("rsync_ferr", 32'(bus.frame_err), 32'h1);
      check("rsync_ecnt", 32'(bus.err_cnt), 32'h2);
      send_str("B3456");
      send_byte(CR);
      check("rsync_val", bus.cmd_val, 32'h3456_00FF);
      check("rsync_set", 32'(bus.cmd_set), 32'h2);
      check("rsync_ecnt2", 32'(bus.err_cnt), 32'h2);

      // Inter-byte timeout
      send_str("!A12");
      for (int i = 1; i <= int'(2 * TMO); i++) begin
         @(negedge clk);
         if (bus.frame_err) begin
            waited = i;
            break;
         end
      end
      check("tmo_latency", 32'(waited), 32'(TMO));
      check("tmo_ecnt", 32'(bus.err_cnt), 32'h3);
      @(negedge clk);
      check("tmo_pulse_end", 32'(bus.frame_err), 32'h0);
      send_str("34");
      send_byte(CR);
      check("tmo_val", bus.cmd_val, 32'h3456_00FF);
      check("tmo_set", 32'(bus.cmd_set), 32'h2);

      // Non-hex digit
      send_str("!A1G");
      check("bad_hex_ferr", 32'(bus.frame_err), 32'h1);
      check("bad_hex_ecnt", 32'(bus.err_cnt), 32'h4);
      send_str("34");
      send_byte(CR);
      check("bad_hex_val", bus.cmd_val, 32'h3456_00FF);
      check("bad_hex_ecnt2", 32'(bus.err_cnt), 32'h4);

      // 260 further errors: '!' repeated inside a frame, each after the first is an error
      for (int i = 0; i < 261; i++) send_byte(8'h21);
      check("sat_ecnt", 32'(bus.err_cnt), 32'hFF);
      check("sat_ferr", 32'(bus.frame_err), 32'h1);
      send_byte(CR);
      check("sat_hold", 32'(bus.err_cnt), 32'hFF);

      // Commit collides with a held clear on the same channel
      bus.cmd_clear = 2'b01;
      send_str("!A0001");
      send_byte(CR);
      check("coll_set", 32'(bus.cmd_set), 32'h3);
      check("coll_val", bus.cmd_val, 32'h3456_0001);
      @(negedge clk);
      check("coll_clr_after", 32'(bus.cmd_set), 32'h2);
      bus.cmd_clear = 2'b00;

      // Asynchronous reset mid-frame
      send_str("!B00");
      #1 rst_n = 1'b0;
      #1;
      check("arst_val", bus.cmd_val, 32'h0);
      check("arst_set", 32'(bus.cmd_set), 32'h0);
      check("arst_ecnt", 32'(bus.err_cnt), 32'h0);
      check("arst_ferr", 32'(bus.frame_err), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send_str("!B0042");
      send_byte(CR);
      check("post_rst_val", bus.cmd_val, 32'h0042_0000);
      check("post_rst_set", 32'(bus.cmd_set), 32'h2);
      check("post_rst_ecnt", 32'(bus.err_cnt), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
Parametrised ASCII command-frame parser for the UART command path. It consumes the byte stream from the UART receiver (byte plus one-cycle valid) and decodes framed hex commands addressed to one of NCH channels, or to all channels at once. For each channel it holds the latest command value and a sticky "new command" flag. It also detects malformed and stalled frames and counts them.

Parameters:
NCH, 2, number of command channels (1..26); channel i is addressed by ASCII 'A'+i
NDIG, 4, hex digits per command; value width W = 4*NDIG
TIMEOUT_CLKS, 43400, clocks allowed between bytes of a frame (10 byte times at 434 clks/bit)

Ports:
clk  in  1  system clock (50 MHz)
rst_n  in  1  asynchronous active-low reset
rx_byte  in  8  received byte, valid only when rx_dv=1
rx_dv  in  1  one-cycle byte-valid strobe from uart_rx
cmd_clear  in  NCH  per-channel acknowledge; clears cmd_set[i]
cmd_val  out  NCH*W  channel i value at [i*W +: W]
cmd_set  out  NCH  sticky per-channel new-command flag
frame_err  out  1  one-cycle pulse on any frame error
err_cnt  out  8  frame error count, saturates at 255

Behaviour:
- Frame format: '!' (0x21), channel char, NDIG hex digits (MSD first), CR (0x0D).
- Channel char: 'A'..'A'+NCH-1 addresses one channel; '*' (0x2A) broadcasts to all channels.
- Hex digits: '0'-'9', 'A'-'F' and 'a'-'f' are accepted, converted to nibble values and shifted into a W-bit accumulator.
- Reset (rst_n low, async): state IDLE; cmd_val=0, cmd_set=0, frame_err=0, err_cnt=0; accumulator and counters cleared. Reset mid-frame discards the partial frame.
- FSM states: IDLE, CHAN, DATA, TERM. Transitions happen only on cycles where rx_dv=1, except timeout.
  - IDLE: '!' -> CHAN. Any other byte is ignored silently (no error).
  - CHAN: valid channel char or '*' -> latch target mask, clear accumulator and digit count, go DATA. Any other byte -> error, IDLE.
  - DATA: hex digit -> shift into accumulator, increment count; after the NDIG-th digit -> TERM. Non-hex byte -> error, IDLE.
  - TERM: CR -> commit, IDLE. Any other byte -> error, IDLE.
- Resync: '!' received in CHAN, DATA or TERM counts as one error and goes to CHAN, not IDLE. The new frame therefore starts immediately.
- Commit timing: registered one clock after the CR's rx_dv cycle.
  - cmd_val[i] is loaded with the accumulator for every i in the target mask.
  - cmd_set[i] is set for every i in the target mask.
  - Channels outside the mask are untouched.
- cmd_clear[i]=1 clears cmd_set[i] on the next edge; cmd_val is retained.
- Simultaneous commit and cmd_clear[i] on the same channel: the set wins, so the new command is never lost. cmd_clear on other channels still applies.
- Timeout:
  - Inter-byte counter resets on every rx_dv and counts while state != IDLE.
  - Reaching TIMEOUT_CLKS with no byte -> error, IDLE.
  - The counter is held at 0 while in IDLE.
- Error handling: frame_err pulses high for exactly one cycle per error; err_cnt increments by 1 and saturates at 255. No outputs other than frame_err and err_cnt change on an error.
- Throughput: one byte per clock is accepted; there is no backpressure.

Decomposition:
- Package uart_cmd_pkg holds:
  - ASCII constants SOF=0x21, BCAST=0x2A, EOF_CR=0x0D, CHAN_BASE=0x41
  - typedef enum for the state type (IDLE/CHAN/DATA/TERM)
  - function is_hex(byte) and function hex2nib(byte) -> 4 bits
- No sub-module. The top level of the UART command path instantiates uart_rx and feeds it into uart_cmd_parser.

Test Plan:
- Single channel (NCH=2, NDIG=4): send "!A12Ef\r" -> one cycle after CR: cmd_val[15:0]=0x12EF, cmd_set=2'b01, cmd_val[31:16]=0, no frame_err.
- Broadcast and clear: send "!*00FF\r" -> both channels =0x00FF, cmd_set=2'b11. Then pulse cmd_clear=2'b10 -> cmd_set=2'b01, both values unchanged.
- Bad channel: send "!C1234\r" -> frame_err pulses on the 'C' byte, err_cnt=1, trailing "1234\r" ignored, outputs unchanged.
- Resync: send "!A12!B3456\r" -> err_cnt=1, ch1=0x3456 with cmd_set[1]=1, ch0 value and flag unchanged.
- Timeout and bad digit:
  - Send "!A12", then idle TIMEOUT_CLKS clocks -> frame_err pulse, FSM returns to IDLE, a following "34\r" is ignored.
  - Send "!A1G34\r" -> error on 'G'.
  - Drive 260 errors -> err_cnt holds at 255.
- Collision and reset:
  - Hold cmd_clear[0]=1 through a "!A0001\r" commit -> cmd_set[0]=1, cmd_val ch0=0x0001.
  - Assert rst_n low mid-frame -> all outputs 0 immediately; a subsequent "!B0042\r" commits correctly.
